// File: rtl/aes_host_loader_pkg.sv
// aes_host_loader_pkg: register map, control/status bit positions and FSM encoding
package aes_host_loader_pkg;
  localparam logic [3:0] A_KEY0 = 4'h0;
  localparam logic [3:0] A_KEY1 = 4'h1;
  localparam logic [3:0] A_KEY2 = 4'h2;
  localparam logic [3:0] A_KEY3 = 4'h3;
  localparam logic [3:0] A_DIN0 = 4'h4;
  localparam logic [3:0] A_DIN1 = 4'h5;
  localparam logic [3:0] A_DIN2 = 4'h6;
  localparam logic [3:0] A_DIN3 = 4'h7;
  localparam logic [3:0] A_CTRL = 4'h8;
  localparam logic [3:0] A_STAT = 4'h9;
  localparam logic [3:0] A_RES0 = 4'hC;
  localparam logic [3:0] A_RES1 = 4'hD;
  localparam logic [3:0] A_RES2 = 4'hE;
  localparam logic [3:0] A_RES3 = 4'hF;
  localparam int CTRL_LOADKEY = 0;
  localparam int CTRL_ENCRYPT = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_KEYOK = 2;
  localparam int STAT_ERR   = 3;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KREQ  = 3'd1,
    S_KWAIT = 3'd2,
    S_DREQ  = 3'd3,
    S_DWAIT = 3'd4
  } state_t;
endpackage

// File: rtl/aes_host_loader_if.sv
// aes_host_loader_if: host register bus plus the AES core handshake bundle
interface aes_host_loader_if;
  logic         wr;
  logic         rd;
  logic [3:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         irq;
  logic [127:0] Kin;
  logic [127:0] Din;
  logic         Krdy;
  logic         Drdy;
  logic         EN;
  logic [127:0] Dout;
  logic         Kvld;
  logic         Dvld;
  logic         BSY;
  modport slave (
    input  wr, rd, addr, wdata, Dout, Kvld, Dvld, BSY,
    output rdata, irq, Kin, Din, Krdy, Drdy, EN
  );
  modport master (
    output wr, rd, addr, wdata, Dout, Kvld, Dvld, BSY,
    input  rdata, irq, Kin, Din, Krdy, Drdy, EN
  );
endinterface

// File: rtl/aes_host_loader_regfile.sv
// aes_host_regfile: key/plaintext/result word registers, write decode and registered read mux
module aes_host_regfile
  import aes_host_loader_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr,
  input  logic         rd,
  input  logic [3:0]   addr,
  input  logic [31:0]  wdata,
  input  logic         idle,
  input  logic         cap,
  input  logic [127:0] dout,
  input  logic [3:0]   status,
  output logic [127:0] kin,
  output logic [127:0] din,
  output logic [31:0]  rdata,
  output logic         ctrl_wr,
  output logic         data_wr
);
  logic [127:0] kin_q, kin_d, din_q, din_d, res_q, res_d;
  logic [31:0]  rdata_q, rdata_d, rmux;
  logic [6:0]   base;
  // word 0 is the most significant word, so the bit offset counts down with the address
  assign base    = {~addr[1:0], 5'd0};
  assign data_wr = wr && (addr < A_CTRL);
  assign ctrl_wr = wr && (addr == A_CTRL);
  assign kin     = kin_q;
  assign din     = din_q;
  assign rdata   = rdata_q;
  // next-state: idle-only operand writes, result capture, read mux sampled on rd
  always_comb begin
    kin_d = kin_q;
    din_d = din_q;
    res_d = cap ? dout : res_q;
    if (data_wr && idle && addr[3:2] == A_KEY0[3:2]) kin_d[base +: 32] = wdata;
    if (data_wr && idle && addr[3:2] == A_DIN0[3:2]) din_d[base +: 32] = wdata;
    rmux = addr[3:2] == A_KEY0[3:2] ? kin_q[base +: 32] :
           addr[3:2] == A_DIN0[3:2] ? din_q[base +: 32] :
           addr[3:2] == A_RES0[3:2] ? res_q[base +: 32] :
           addr == A_STAT           ? {28'd0, status}   : 32'd0;
    rdata_d = rd ? rmux : rdata_q;
  end
  // register storage with asynchronous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kin_q   <= '0;
      din_q   <= '0;
      res_q   <= '0;
      rdata_q <= '0;
    end else begin
      kin_q   <= kin_d;
      din_q   <= din_d;
      res_q   <= res_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: rtl/aes_host_loader.sv
// aes_host_loader: word-serial host front end sequencing key load and encryption on an AES core
module aes_host_loader
  import aes_host_loader_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input logic CLK,
  input logic RST,
  aes_host_loader_if.slave bus
);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        keyok_q, keyok_d, done_q, done_d, err_q, err_d, enc_q, enc_d;
  logic        krdy_q, krdy_d, en_q, en_d;
  logic        idle, expired, ctrl_wr, data_wr;
  logic [3:0]  status;
  assign idle    = state_q == S_IDLE;
  assign expired = cnt_q == 8'(TIMEOUT - 1);
  assign status  = {err_q, keyok_q, done_q, !idle};
  assign bus.Krdy = krdy_q;
  assign bus.Drdy = state_q == S_DREQ && !bus.BSY;
  assign bus.EN   = en_q;
  assign bus.irq  = done_q || err_q;
  aes_host_regfile u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .wr      (bus.wr),
    .rd      (bus.rd),
    .addr    (bus.addr),
    .wdata   (bus.wdata),
    .idle    (idle),
    .cap     (state_q == S_DWAIT && bus.Dvld),
    .dout    (bus.Dout),
    .status  (status),
    .kin     (bus.Kin),
    .din     (bus.Din),
    .rdata   (bus.rdata),
    .ctrl_wr (ctrl_wr),
    .data_wr (data_wr)
  );
  // handshake sequencing, status flags and per-state timeout counter
  always_comb begin
    state_d = state_q;
    keyok_d = keyok_q;
    done_d  = done_q;
    err_d   = err_q;
    enc_d   = enc_q;
    en_d    = 1'b1;
    if ((data_wr || ctrl_wr) && !idle) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && bus.wdata[CTRL_LOADKEY]) begin
          state_d = S_KREQ;
          enc_d   = bus.wdata[CTRL_ENCRYPT];
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (ctrl_wr && bus.wdata[CTRL_ENCRYPT]) begin
          state_d = keyok_q ? S_DREQ : S_IDLE;
          done_d  = keyok_q ? 1'b0 : done_q;
          err_d   = !keyok_q;
        end
      end
      S_KREQ: state_d = S_KWAIT;
      S_KWAIT: begin
        if (bus.Kvld) begin
          keyok_d = 1'b1;
          state_d = enc_q ? S_DREQ : S_IDLE;
        end else if (expired) begin
          keyok_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DREQ: begin
        if (!bus.BSY) state_d = S_DWAIT;
        else if (expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DWAIT: begin
        if (bus.Dvld) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d  = state_d != state_q ? 8'd0 : cnt_q + 8'd1;
    krdy_d = state_d == S_KREQ;
  end
  // control state registers with asynchronous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      keyok_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      enc_q   <= 1'b0;
      krdy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keyok_q <= keyok_d;
      done_q  <= done_d;
      err_q   <= err_d;
      enc_q   <= enc_d;
      krdy_q  <= krdy_d;
      en_q    <= en_d;
    end
  end
endmodule

// File: tb/tb_aes_host_loader.sv
// tb_aes_host_loader: directed host sequences against a behavioural AES core model
module tb_aes_host_loader;
  import aes_host_loader_pkg::*;
  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] PT3  = 128'ha5a5a5a5_0f0f0f0f_12345678_9abcdef0;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic drop = 1'b0;
  int npass = 0;
  int ntot = 0;
  int cyc = 0, nk = 0, nd = 0, kvld_cyc = 0, drdy_cyc = 0;
  logic [3:0] dcnt;
  logic [127:0] kl, dl;
  aes_host_loader_if bus();
  aes_host_loader #(.TIMEOUT(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d);
    return (k == FKEY && d == FPT) ? FCT : k ^ d;
  endfunction
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.Kvld <= 1'b0;
      bus.Dvld <= 1'b0;
      bus.BSY  <= 1'b0;
      bus.Dout <= '0;
      dcnt     <= '0;
      kl       <= '0;
      dl       <= '0;
    end else begin
      bus.Kvld <= bus.Krdy;
      bus.Dvld <= 1'b0;
      if (bus.Drdy) begin
        bus.BSY <= 1'b1;
        dcnt    <= 4'd11;
        kl      <= bus.Kin;
        dl      <= bus.Din;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 4'd1;
        if (dcnt == 4'd1) begin
          bus.BSY  <= 1'b0;
          bus.Dvld <= !drop;
          bus.Dout <= cipher(kl, dl);
        end
      end
    end
  end
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (bus.Krdy) nk <= nk + 1;
    if (bus.Drdy) begin
      nd <= nd + 1;
      drdy_cyc <= cyc;
    end
    if (bus.Kvld) kvld_cyc <= cyc;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.wr = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    @(negedge CLK);
    bus.wr = 1'b0;
  endtask
  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    bus.rd = 1'b1;
    bus.addr = a;
    @(negedge CLK);
    bus.rd = 1'b0;
    d = bus.rdata;
  endtask
  task automatic wr_block(input logic [3:0] a0, input logic [127:0] v);
    for (int i = 0; i < 4; i++) wr_reg(a0 + 4'(i), v[127 - 32*i -: 32]);
  endtask
  task automatic check_result(input string tag, input logic [127:0] exp);
    logic [31:0] w;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      rd_reg(A_RES0 + 4'(i), w);
      r[127 - 32*i -: 32] = w;
    end
    check(tag, r, exp);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_kin"}, bus.Kin, '0);
    check({tag, "_din"}, bus.Din, '0);
    check({tag, "_pulses"}, {bus.Krdy, bus.Drdy, bus.EN, bus.irq}, '0);
    check({tag, "_rdata"}, bus.rdata, '0);
  endtask
  initial begin
    logic [31:0] s;
    int k0, d0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst0");
    RST = 1'b0;
    #1 check("en_before_edge", bus.EN, 1'b0);
    @(negedge CLK);
    check("en_after_edge", bus.EN, 1'b1);
    rd_reg(A_STAT, s);
    check("stat_reset", s, 32'h0);
    d0 = nd;
    wr_reg(A_CTRL, 32'h2);
    repeat (3) @(negedge CLK);
    rd_reg(A_STAT, s);
    check("nokey_stat", s, 32'h8);
    check("nokey_irq", bus.irq, 1'b1);
    check("nokey_no_drdy", nd - d0, 0);
    wr_block(A_KEY0, FKEY);
    wr_block(A_DIN0, FPT);
    rd_reg(A_KEY1, s);
    check("key1_readback", s, 32'h04050607);
    k0 = nk;
    d0 = nd;
    wr_reg(A_CTRL, 32'h3);
    repeat (25) @(negedge CLK);
    check("kat_kin", bus.Kin, FKEY);
    check("kat_din", bus.Din, FPT);
    check("kat_krdy_count", nk - k0, 1);
    check("kat_drdy_count", nd - d0, 1);
    check("kat_drdy_after_kvld", drdy_cyc - kvld_cyc, 1);
    check_result("kat_result", FCT);
    rd_reg(A_STAT, s);
    check("kat_stat", s, 32'h6);
    check("kat_irq", bus.irq, 1'b1);
    wr_block(A_DIN0, PT2);
    k0 = nk;
    d0 = nd;
    wr_reg(A_CTRL, 32'h2);
    rd_reg(A_STAT, s);
    check("b2b_stat_start", s, 32'h5);
    repeat (25) @(negedge CLK);
    check("b2b_no_krdy", nk - k0, 0);
    check("b2b_drdy_count", nd - d0, 1);
    check_result("b2b_result", FKEY ^ PT2);
    rd_reg(A_STAT, s);
    check("b2b_stat_end", s, 32'h6);
    wr_block(A_DIN0, PT3);
    k0 = nk;
    wr_reg(A_CTRL, 32'h2);
    repeat (4) @(negedge CLK);
    wr_reg(A_DIN0, 32'hdeadbeef);
    wr_reg(A_CTRL, 32'h1);
    check("busy_din_kept", bus.Din, PT3);
    rd_reg(A_STAT, s);
    check("busy_stat_err", s, 32'hD);
    repeat (25) @(negedge CLK);
    check("busy_no_krdy", nk - k0, 0);
    check_result("busy_result", FKEY ^ PT3);
    rd_reg(A_STAT, s);
    check("busy_stat_end", s, 32'hE);
    drop = 1'b1;
    wr_reg(A_CTRL, 32'h2);
    repeat (10) @(negedge CLK);
    rd_reg(A_STAT, s);
    check("to_stat_waiting", s, 32'h5);
    repeat (40) @(negedge CLK);
    rd_reg(A_STAT, s);
    check("to_stat", s, 32'hC);
    check("to_irq", bus.irq, 1'b1);
    drop = 1'b0;
    rd_reg(4'hA, s);
    check("unmapped_read", s, 32'h0);
    wr_reg(A_RES0, 32'h12345678);
    check_result("ro_result", FKEY ^ PT3);
    wr_reg(A_CTRL, 32'h2);
    repeat (5) @(negedge CLK);
    rd_reg(A_KEY0, s);
    check("mid_key0", s, 32'h00010203);
    d0 = nd;
    #3 RST = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1 check("mid_en_before_edge", bus.EN, 1'b0);
    @(negedge CLK);
    check("mid_en_after_edge", bus.EN, 1'b1);
    repeat (20) @(negedge CLK);
    check("mid_no_drdy", nd - d0, 0);
    rd_reg(A_STAT, s);
    check("mid_stat", s, 32'h0);
    check_result("mid_result", '0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
